// File: rtl/bench_bist_ctrl.sv
// BIST sequencer: flushes the circuit under test, applies LFSR patterns and
// compresses the CUT responses into a 16-bit MISR signature.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for START; SIG/PAT_CNT hold the previous result
// INIT    | flushing the CUT with DUT_IN=0 for INIT_CYC stepped cycles
// APPLY   | current pattern driven, CUT not stepped (settle cycle)
// CAPTURE | CUT stepped, response folded into the MISR, LFSR advanced
// DONE    | run complete; result held until the next accepted START
module bench_bist_ctrl #(
    parameter int unsigned INIT_CYC = 8
) (
    input  logic        CK,
    input  logic        RST,
    input  logic        START,
    input  logic        ABORT,
    input  logic [15:0] NUM_PAT,
    input  logic [6:0]  SEED,
    input  logic [6:0]  DUT_OUT,
    output logic [6:0]  DUT_IN,
    output logic        DUT_STEP,
    output logic        DUT_INIT,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] SIG,
    output logic [15:0] PAT_CNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_APPLY,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [7:0] INIT_LAST = 8'(INIT_CYC - 1);

    state_t      state;
    state_t      state_nx;
    logic [7:0]  init_cnt;
    logic [15:0] num_pat_q;
    logic [6:0]  lfsr;
    logic [15:0] misr;
    logic [15:0] pat_cnt;
    logic        start_ok;
    logic        init_last;
    logic        cap_last;

    assign start_ok  = ((state == S_IDLE) || (state == S_DONE)) && START && !ABORT;
    assign init_last = (init_cnt == INIT_LAST);
    // 17-bit compare so a count of 16'hFFFF terminates without wrapping
    assign cap_last  = (({1'b0, pat_cnt} + 17'd1) == {1'b0, num_pat_q});

    always_ff @(posedge CK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_nx = S_INIT;
                end
            end
            S_INIT: begin
                if (init_last) begin
                    state_nx = (num_pat_q == 16'd0) ? S_DONE : S_APPLY;
                end
            end
            S_APPLY:   state_nx = S_CAPTURE;
            S_CAPTURE: state_nx = cap_last ? S_DONE : S_APPLY;
            default:   state_nx = S_IDLE;
        endcase
        if (ABORT) begin
            state_nx = S_IDLE;
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            init_cnt  <= 8'd0;
            num_pat_q <= 16'd0;
            lfsr      <= 7'h01;
            misr      <= 16'h0000;
            pat_cnt   <= 16'd0;
        end else if (start_ok) begin
            init_cnt  <= 8'd0;
            num_pat_q <= NUM_PAT;
            lfsr      <= (SEED == 7'h00) ? 7'h01 : SEED;
            misr      <= 16'h0000;
            pat_cnt   <= 16'd0;
        end else begin
            case (state)
                S_INIT: init_cnt <= init_cnt + 8'd1;
                S_CAPTURE: begin
                    lfsr    <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
                    misr    <= {misr[14:0], 1'b0} ^ (misr[15] ? 16'h1021 : 16'h0000)
                               ^ {9'b0, DUT_OUT};
                    pat_cnt <= pat_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign DUT_IN   = ((state == S_APPLY) || (state == S_CAPTURE)) ? lfsr : 7'h00;
    assign DUT_STEP = (state == S_INIT) || (state == S_CAPTURE);
    assign DUT_INIT = (state == S_INIT);
    assign BUSY     = (state == S_INIT) || (state == S_APPLY) || (state == S_CAPTURE);
    assign DONE     = (state == S_DONE);
    assign SIG      = misr;
    assign PAT_CNT  = pat_cnt;

endmodule

// File: doc/bench_bist_ctrl.md
BENCH_BIST_CTRL -- requirements
Module: bench_bist_ctrl

Interface
REQ-001 Parameter INIT_CYC, default 8: number of flush cycles applied to the circuit under test (CUT) before the first pattern; legal range 1..255.
REQ-002 CK  in  1  clock; all state updates on rising edge.
REQ-003 RST  in  1  synchronous, active-high reset.
REQ-004 START  in  1  run request; sampled only in IDLE and DONE.
REQ-005 ABORT  in  1  terminate run and return to IDLE.
REQ-006 NUM_PAT  in  16  pattern count; latched when START is accepted.
REQ-007 SEED  in  7  pattern LFSR seed; latched when START is accepted.
REQ-008 DUT_OUT  in  7  CUT primary outputs.
REQ-009 DUT_IN  out  7  CUT primary inputs.
REQ-010 DUT_STEP  out  1  CUT clock-enable; the CUT flip-flops advance on an edge where it is 1.
REQ-011 DUT_INIT  out  1  high while flushing.
REQ-012 BUSY  out  1  high in INIT, APPLY and CAPTURE.
REQ-013 DONE  out  1  high in DONE state.
REQ-014 SIG  out  16  MISR signature.
REQ-015 PAT_CNT  out  16  patterns captured in current or last run.

Function
REQ-016 FSM states: IDLE, INIT, APPLY, CAPTURE, DONE; all outputs are registered or decoded from the registered state only.
REQ-017 IDLE/DONE with START=1 and ABORT=0 -> INIT. The block latches NUM_PAT, loads LFSR=SEED (7'h01 if SEED==0), clears MISR and PAT_CNT, and clears the INIT counter.
REQ-018 INIT: DUT_IN=7'h00, DUT_STEP=1, DUT_INIT=1 for exactly INIT_CYC cycles. It then moves to APPLY, or to DONE if the latched NUM_PAT==0.
REQ-019 APPLY (one cycle): DUT_IN=LFSR, DUT_STEP=0 (settle) -> CAPTURE.
REQ-020 CAPTURE (one cycle): DUT_IN=LFSR, DUT_STEP=1. The MISR samples DUT_OUT, the LFSR advances and PAT_CNT increments. If PAT_CNT+1==NUM_PAT the FSM moves to DONE; otherwise it moves to APPLY.
REQ-021 LFSR update: next = {lfsr[5:0], lfsr[6]^lfsr[5]} (maximal length, period 127).
REQ-022 MISR update: next = {misr[14:0],1'b0} ^ (misr[15] ? 16'h1021 : 16'h0000) ^ {9'b0, DUT_OUT}.
REQ-023 Run latency: if START is accepted at edge k, DONE rises after edge k+INIT_CYC+2*NUM_PAT.
REQ-024 DONE: DUT_IN=0, DUT_STEP=0, BUSY=0. SIG and PAT_CNT hold until the next accepted START.
REQ-025 START is ignored while BUSY=1. NUM_PAT and SEED changes after acceptance have no effect.
REQ-026 ABORT=1 in any state -> IDLE on the next edge, with DUT_STEP=0 and DONE=0. SIG and PAT_CNT hold their last values. ABORT takes priority over START.
REQ-027 NUM_PAT=16'hFFFF is legal; PAT_CNT never wraps.

Reset
REQ-028 RST=1 at any edge, including mid-run, forces IDLE. It also sets DUT_IN=0, DUT_STEP=0, DUT_INIT=0, BUSY=0, DONE=0, SIG=16'h0000, PAT_CNT=0, LFSR=7'h01, and clears the INIT counter.
REQ-029 RST has priority over ABORT and START.

Verification
REQ-030 INIT_CYC=8, SEED=7'h01, NUM_PAT=3, DUT_OUT tied 7'h01, START at edge k:
- DUT_IN sequence in APPLY/CAPTURE is 01,02,04.
- DONE rises after edge k+14.
- SIG=16'h0007, PAT_CNT=3.
REQ-031 Same run with DUT_OUT tied 7'h7F -> SIG=16'h017D. Same run with DUT_OUT tied 7'h00 -> SIG=16'h0000.
REQ-032 SEED=7'h00, NUM_PAT=2 -> applied patterns 7'h01, 7'h02, PAT_CNT=2. NUM_PAT=0 -> DONE after exactly INIT_CYC flush cycles, SIG=0.
REQ-033 Interrupt cases:
- ABORT asserted in second CAPTURE -> IDLE next cycle, PAT_CNT=2, DONE=0.
- START asserted while BUSY -> no effect.
- START+ABORT together in IDLE -> stays IDLE.
REQ-034 RST asserted mid-APPLY -> all outputs at reset values next cycle. A following START runs a complete, correct sequence.
REQ-035 LFSR period check: SEED=7'h01, NUM_PAT=127 -> 127 distinct nonzero DUT_IN values, with the LFSR returning to 7'h01.
